// File: rtl/fpcvt_stream.sv
// rtl/fpcvt_stream.sv - streaming fixed-to-float converter, iterative normalise, round half up, saturate.
// Optional sat/inexact outputs enabled by FPCVT_FLAGS_EN.
module fpcvt_stream #(
  parameter int EW = 3,
  parameter int FW = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [FW+(1<<EW)-1:0]     D,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      S,
  output logic [EW-1:0]             E,
  output logic [FW-1:0]             F
`ifdef FPCVT_FLAGS_EN
  ,
  output logic                      sat,
  output logic                      inexact
`endif
);

  localparam int W = FW + (1 << EW);
  localparam logic [EW-1:0] EMAX = '1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_NORM  = 2'd1;
  localparam logic [1:0] ST_ROUND = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [W-2:0]  mag_q, mag_d;
  logic [EW-1:0] e_q, e_d;
  logic          s_q, s_d;
  logic          S_q, S_d;
  logic [EW-1:0] E_q, E_d;
  logic [FW-1:0] F_q, F_d;

  logic          d_min;
  logic [W-2:0]  d_mag;
  logic [FW:0]   rnd_sum;
  logic          rnd_ovf;

  // Most negative input has no positive twin in W-1 bits, so it clamps to all ones.
  always_comb begin
    d_min = D[W-1] & ~(|D[W-2:0]);
    if (d_min)
      d_mag = '1;
    else if (D[W-1])
      d_mag = ~D[W-2:0] + 1'b1;
    else
      d_mag = D[W-2:0];
  end

  always_comb begin
    rnd_sum = {1'b0, mag_q[W-2 -: FW]} + {{FW{1'b0}}, mag_q[W-2-FW]};
    rnd_ovf = rnd_sum[FW];
  end

`ifdef FPCVT_FLAGS_EN
  logic min_q, min_d;
  logic sat_q, sat_d;
  logic inex_q, inex_d;
`endif

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    e_d     = e_q;
    s_d     = s_q;
    S_d     = S_q;
    E_d     = E_q;
    F_d     = F_q;
`ifdef FPCVT_FLAGS_EN
    min_d   = min_q;
    sat_d   = sat_q;
    inex_d  = inex_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          s_d     = D[W-1];
          mag_d   = d_mag;
          e_d     = EMAX;
          state_d = ST_NORM;
`ifdef FPCVT_FLAGS_EN
          min_d   = d_min;
`endif
        end
      end
      ST_NORM: begin
        if (mag_q[W-2] || (e_q == '0)) begin
          state_d = ST_ROUND;
        end else begin
          mag_d = {mag_q[W-3:0], 1'b0};
          e_d   = e_q - 1'b1;
        end
      end
      ST_ROUND: begin
        S_d = s_q;
        if (!rnd_ovf) begin
          F_d = rnd_sum[FW-1:0];
          E_d = e_q;
        end else if (e_q != EMAX) begin
          F_d = {1'b1, {(FW-1){1'b0}}};
          E_d = e_q + 1'b1;
        end else begin
          F_d = '1;
          E_d = EMAX;
        end
`ifdef FPCVT_FLAGS_EN
        sat_d  = min_q | (rnd_ovf & (e_q == EMAX));
        inex_d = (|mag_q[W-2-FW:0]) | min_q | (rnd_ovf & (e_q == EMAX));
`endif
        state_d = ST_HOLD;
      end
      default: begin
        if (out_ready)
          state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mag_q   <= '0;
      e_q     <= '0;
      s_q     <= 1'b0;
      S_q     <= 1'b0;
      E_q     <= '0;
      F_q     <= '0;
`ifdef FPCVT_FLAGS_EN
      min_q   <= 1'b0;
      sat_q   <= 1'b0;
      inex_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      e_q     <= e_d;
      s_q     <= s_d;
      S_q     <= S_d;
      E_q     <= E_d;
      F_q     <= F_d;
`ifdef FPCVT_FLAGS_EN
      min_q   <= min_d;
      sat_q   <= sat_d;
      inex_q  <= inex_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_HOLD);
  assign S         = S_q;
  assign E         = E_q;
  assign F         = F_q;
`ifdef FPCVT_FLAGS_EN
  assign sat       = sat_q;
  assign inexact   = inex_q;
`endif

endmodule

// File: tb/tb_fpcvt_stream.sv
// tb/tb_fpcvt_stream.sv - directed self-checking bench for fpcvt_stream.
module tb_fpcvt_stream;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] D;
  logic        out_valid;
  logic        out_ready;
  logic        S;
  logic [2:0]  E;
  logic [3:0]  F;
`ifdef FPCVT_FLAGS_EN
  logic        sat;
  logic        inexact;
`endif

  int checks   = 0;
  int failures = 0;

  fpcvt_stream #(.EW(3), .FW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .D         (D),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .E         (E),
    .F         (F)
`ifdef FPCVT_FLAGS_EN
    ,
    .sat       (sat),
    .inexact   (inexact)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one word, wait for the result, check it, then complete the output handshake.
  task automatic convert(input string tag, input logic [11:0] d, input logic es, input logic [2:0] ee,
                         input logic [3:0] ef, input int elat, input logic esat, input logic einx);
    int lat;
    @(negedge clk);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    D        = d;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(elat));
    chk({tag, "_S"}, 32'(S), 32'(es));
    chk({tag, "_E"}, 32'(E), 32'(ee));
    chk({tag, "_F"}, 32'(F), 32'(ef));
`ifdef FPCVT_FLAGS_EN
    chk({tag, "_sat"}, 32'(sat), 32'(esat));
    chk({tag, "_inexact"}, 32'(inexact), 32'(einx));
`else
    if (esat && einx) begin end
`endif
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_ready_after"}, 32'(in_ready), 32'd1);
    chk({tag, "_valid_after"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int lat;
    int stale;
    logic [2:0] hold_e;
    logic [3:0] hold_f;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    D         = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_SEF", {25'd0, S, E, F}, 32'd0);

    convert("p7ff", 12'h7FF, 1'b0, 3'd7, 4'b1111, 2, 1'b1, 1'b1);
    convert("p155", 12'h155, 1'b0, 3'd5, 4'b1011, 4, 1'b0, 1'b1);
    convert("p069", 12'h069, 1'b0, 3'd3, 4'b1101, 6, 1'b0, 1'b1);
    convert("p07d", 12'h07D, 1'b0, 3'd4, 4'b1000, 6, 1'b0, 1'b1);
    convert("n800", 12'h800, 1'b1, 3'd7, 4'b1111, 2, 1'b1, 1'b1);
    convert("nfff", 12'hFFF, 1'b1, 3'd0, 4'b0001, 9, 1'b0, 1'b0);
    convert("z000", 12'h000, 1'b0, 3'd0, 4'b0000, 9, 1'b0, 1'b0);

    // Backpressure: result must stay frozen while downstream stalls.
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    D        = 12'h155;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk("bp_latency", 32'(lat), 32'd4);
    hold_e = E;
    hold_f = F;
    chk("bp_E", 32'(hold_e), 32'd5);
    chk("bp_F", 32'(hold_f), 32'hB);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_SEF", {25'd0, S, E, F}, {25'd0, 1'b0, 3'd5, 4'hB});
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    chk("bp_release_valid", 32'(out_valid), 32'd0);

    // Reset during NORM of a long conversion.
    in_valid = 1'b1;
    D        = 12'hFFF;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_SEF", {25'd0, S, E, F}, 32'd0);
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("rst_no_stale", 32'(stale), 32'd0);

    convert("post_rst", 12'h069, 1'b0, 3'd3, 4'b1101, 6, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpcvt_stream.md
Name: fpcvt_stream

Overview:
- Sequential, parametrised successor to the combinational 12-bit fixed-to-float converter.
- Converts a two's-complement integer of width W = FW + 2^EW into sign/exponent/mantissa form (value = F × 2^E) with round-to-nearest (half up) and saturation.
- Normalisation is iterative, one shift per cycle. Valid/ready handshakes on input and output let it sit between stream stages in the datapath.

Parameters:
- EW, 3, exponent width; max exponent EMAX = 2^EW - 1.
- FW, 4, mantissa width. Input width W = FW + 2^EW is a derived localparam (12 at defaults).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  D is valid.
- in_ready  out  1  block can accept D.
- D  in  W  two's-complement input.
- out_valid  out  1  S/E/F valid.
- out_ready  in  1  downstream accepts result.
- S  out  1  sign.
- E  out  EW  exponent.
- F  out  FW  mantissa.

Behaviour:
- Reset: sampled on clk edge with rst_n=0. Forces state IDLE, in_ready=1, out_valid=0, S=0, E=0, F=0, and discards any in-flight conversion, including mid-NORM/ROUND/HOLD.
- States: IDLE, NORM, ROUND, HOLD. in_ready=1 only in IDLE. out_valid=1 only in HOLD.
- IDLE, on in_valid && in_ready:
  - s_r = D[W-1].
  - mag (W-1 bits) = |D|; D = -2^(W-1) saturates mag to 2^(W-1)-1.
  - e_r = EMAX. Go to NORM.
- NORM, each cycle:
  - If mag[W-2]=1 or e_r=0, go to ROUND.
  - Else mag <= mag<<1 (zero fill) and e_r <= e_r-1.
  - The shift count s is the number of leading zeros of mag, capped at EMAX.
- ROUND:
  - f = mag[W-2 -: FW]; r = mag[W-2-FW].
  - f+r ≤ 2^FW-1: F=f+r, E=e_r.
  - Mantissa overflow with e_r<EMAX: F = 1 followed by FW-1 zeros, E = e_r+1.
  - Overflow with e_r=EMAX: saturate to F=all ones, E=EMAX.
  - S=s_r. Go to HOLD.
  - When e_r=0 (denormal), F holds the low FW bits of the original magnitude; r is always 0 there.
- HOLD: S/E/F/out_valid held stable while out_ready=0. On out_ready=1, go to IDLE (in_ready=1 the next cycle).
- Latency: out_valid rises s+2 cycles after the accepting edge (min 2, max EMAX+2 = 9 at defaults).
- Throughput: one conversion per s+4 cycles at best; no overlap.
- S/E/F registered; they retain the last result after the handshake until the next ROUND.
- in_valid while busy is ignored; the upstream must hold D until in_ready.
- Sign of zero: D=0 gives S=0, E=0, F=0.

Optional Feature:
- Macro FPCVT_FLAGS_EN, when defined, adds two outputs, each 1 bit, registered in ROUND, reset 0, valid with out_valid:
  - sat: input was -2^(W-1), or exponent overflow forced saturation.
  - inexact: any nonzero bit in mag[W-2-FW:0] at ROUND, or sat=1.
- Undefined: the ports and logic are absent; S/E/F behaviour is identical either way.

Test Plan:
- D=0x7FF, out_ready=1: s=0, out_valid after 2 cycles; S=0, E=7, F=1111 (saturated; sat=1, inexact=1 with FPCVT_FLAGS_EN).
- D=0x155: s=2, out_valid after 4 cycles; S=0, E=5, F=1011 (rounded up from 1010).
- D=0x069 then D=0x07D back-to-back:
  - 0x069 gives E=3, F=1101 (no round).
  - 0x07D gives E=4, F=1000 (mantissa overflow carries into exponent).
- D=0x800 gives S=1, E=7, F=1111. D=0xFFF gives S=1, E=0, F=0001 after 9 cycles (max latency, denormal). D=0x000 gives S=0, E=0, F=0000.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD. S/E/F/out_valid stay stable and in_ready stays 0. Then out_ready=1 gives in_ready=1 the next cycle.
- Reset mid-op: rst_n=0 for one edge during NORM. The next cycle shows in_ready=1, out_valid=0, S/E/F=0, and no stale result emerges.
